// File: rtl/alarm_clk_pkg.sv
// Shared types and wrap helpers for the alarm clock core.
// ALARM_CLK_SNOOZE_EN adds the SNOOZED state to the FSM encoding.
package alarm_clk_pkg;

  localparam int HOURS_MAX  = 23;
  localparam int MINSEC_MAX = 59;

  typedef struct packed {
    logic [4:0] hh;
    logic [5:0] mm;
    logic [5:0] ss;
  } hms_t;

`ifdef ALARM_CLK_SNOOZE_EN
  typedef enum logic [1:0] {ST_IDLE, ST_RINGING, ST_SNOOZED} alarm_state_t;
`else
  typedef enum logic [1:0] {ST_IDLE, ST_RINGING} alarm_state_t;
`endif

  function automatic logic [4:0] inc_hh(input logic [4:0] v);
    return (v == 5'(HOURS_MAX)) ? 5'd0 : v + 5'd1;
  endfunction

  function automatic logic [5:0] inc_ms(input logic [5:0] v);
    return (v == 6'(MINSEC_MAX)) ? 6'd0 : v + 6'd1;
  endfunction

endpackage

// File: rtl/alarm_clk_core_tick_gen.sv
// One-second prescaler: pulses tick on the terminal count, clr restarts the second.
module tick_gen #(
  parameter int CLK_FREQ_HZ = 100000000
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic tick
);

  localparam int CNT_W = (CLK_FREQ_HZ > 1) ? $clog2(CLK_FREQ_HZ) : 1;
  localparam logic [CNT_W-1:0] TERM = CNT_W'(CLK_FREQ_HZ - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == TERM);

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clr || tick) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/alarm_clk_core.sv
// 24h clock with N_ALARMS alarm channels and a ring/snooze FSM.
// Snooze support is compiled in with ALARM_CLK_SNOOZE_EN.
module alarm_clk_core
  import alarm_clk_pkg::*;
#(
  parameter int CLK_FREQ_HZ  = 100000000,
  parameter int N_ALARMS     = 4,
  parameter int RING_SECONDS = 60,
  parameter int SNOOZE_MIN   = 5
) (
  input  logic                                          clk,
  input  logic                                          reset,
  input  logic [$clog2(N_ALARMS+1)-1:0]                 sel,
  input  logic [1:0]                                    edit_btns,
  input  logic [N_ALARMS-1:0]                           alarm_en,
  input  logic                                          snooze_btn,
  input  logic                                          stop_btn,
  output logic                                          alarm,
  output logic [(N_ALARMS > 1 ? $clog2(N_ALARMS) : 1)-1:0] alarm_id,
  output logic [16:0]                                   disp_time
);

  localparam int ID_W = (N_ALARMS > 1) ? $clog2(N_ALARMS) : 1;
  localparam int RC_W = $clog2(RING_SECONDS + 1);

  hms_t             time_q, time_d, tnext;
  logic [4:0]       al_hh_q [N_ALARMS];
  logic [4:0]       al_hh_d [N_ALARMS];
  logic [5:0]       al_mm_q [N_ALARMS];
  logic [5:0]       al_mm_d [N_ALARMS];
  logic [16:0]      disp_q, disp_d;
  logic             tick, clk_edit, clk_tick, hit, trig, cur_en;
  logic [ID_W-1:0]  trig_id;
  alarm_state_t     state_q;
  logic             alarm_q;
  logic [ID_W-1:0]  alarm_id_q;
  logic [RC_W-1:0]  ring_cnt_q;

  tick_gen #(.CLK_FREQ_HZ(CLK_FREQ_HZ)) u_tick (
    .clk   (clk),
    .reset (reset),
    .clr   ((sel == '0) && edit_btns[0]),
    .tick  (tick)
  );

  // A clock edit swallows any tick landing in the same cycle.
  assign clk_edit = (sel == '0) && (edit_btns != 2'b00);
  assign clk_tick = tick && !clk_edit;

  always_comb begin
    tnext    = time_q;
    tnext.ss = inc_ms(time_q.ss);
    if (time_q.ss == 6'(MINSEC_MAX)) begin
      tnext.mm = inc_ms(time_q.mm);
      if (time_q.mm == 6'(MINSEC_MAX)) tnext.hh = inc_hh(time_q.hh);
    end
  end

  always_comb begin
    time_d = time_q;
    if (clk_edit) begin
      if (edit_btns[1]) time_d.hh = inc_hh(time_q.hh);
      if (edit_btns[0]) begin
        time_d.mm = inc_ms(time_q.mm);
        time_d.ss = 6'd0;
      end
    end else if (clk_tick) begin
      time_d = tnext;
    end
  end

  always_comb begin
    disp_d = time_q;
    for (int k = 0; k < N_ALARMS; k++) begin
      al_hh_d[k] = al_hh_q[k];
      al_mm_d[k] = al_mm_q[k];
      if (int'(sel) == k + 1) begin
        disp_d = {al_hh_q[k], al_mm_q[k], 6'd0};
        if (edit_btns[1]) al_hh_d[k] = inc_hh(al_hh_q[k]);
        if (edit_btns[0]) al_mm_d[k] = inc_ms(al_mm_q[k]);
      end
    end
  end

  // Descending scan so the lowest matching channel is the one kept.
  always_comb begin
    hit     = 1'b0;
    trig_id = '0;
    for (int k = N_ALARMS - 1; k >= 0; k--) begin
      if (alarm_en[k] && (al_hh_q[k] == tnext.hh) && (al_mm_q[k] == tnext.mm)) begin
        hit     = 1'b1;
        trig_id = ID_W'(k);
      end
    end
    cur_en = 1'b0;
    for (int k = 0; k < N_ALARMS; k++) begin
      if (alarm_id_q == ID_W'(k)) cur_en = alarm_en[k];
    end
  end

  assign trig = clk_tick && (tnext.ss == 6'd0) && hit;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      time_q <= '0;
      disp_q <= '0;
      for (int k = 0; k < N_ALARMS; k++) begin
        al_hh_q[k] <= '0;
        al_mm_q[k] <= '0;
      end
    end else begin
      time_q  <= time_d;
      disp_q  <= disp_d;
      al_hh_q <= al_hh_d;
      al_mm_q <= al_mm_d;
    end
  end

`ifdef ALARM_CLK_SNOOZE_EN
  logic [4:0] snz_hh_q, snz_hh_new;
  logic [5:0] snz_mm_q, snz_mm_new;
  logic [6:0] snz_sum;
  logic       snz_hit;

  always_comb begin
    snz_sum    = {1'b0, time_q.mm} + 7'(SNOOZE_MIN);
    snz_hh_new = time_q.hh;
    snz_mm_new = snz_sum[5:0];
    if (snz_sum > 7'(MINSEC_MAX)) begin
      snz_mm_new = 6'(snz_sum - 7'd60);
      snz_hh_new = inc_hh(time_q.hh);
    end
  end

  assign snz_hit = clk_tick && (tnext.ss == 6'd0) &&
                   (tnext.hh == snz_hh_q) && (tnext.mm == snz_mm_q);
`else
  logic snooze_unused;
  assign snooze_unused = snooze_btn & (SNOOZE_MIN > 0);
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      alarm_q    <= 1'b0;
      alarm_id_q <= '0;
      ring_cnt_q <= '0;
`ifdef ALARM_CLK_SNOOZE_EN
      snz_hh_q   <= '0;
      snz_mm_q   <= '0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (trig) begin
            state_q    <= ST_RINGING;
            alarm_q    <= 1'b1;
            alarm_id_q <= trig_id;
            ring_cnt_q <= '0;
          end
        end
        ST_RINGING: begin
          if (stop_btn || !cur_en) begin
            state_q <= ST_IDLE;
            alarm_q <= 1'b0;
`ifdef ALARM_CLK_SNOOZE_EN
          end else if (snooze_btn) begin
            state_q  <= ST_SNOOZED;
            alarm_q  <= 1'b0;
            snz_hh_q <= snz_hh_new;
            snz_mm_q <= snz_mm_new;
`endif
          end else if (clk_tick) begin
            if (ring_cnt_q == RC_W'(RING_SECONDS - 1)) begin
              state_q <= ST_IDLE;
              alarm_q <= 1'b0;
            end else begin
              ring_cnt_q <= ring_cnt_q + 1'b1;
            end
          end
        end
`ifdef ALARM_CLK_SNOOZE_EN
        ST_SNOOZED: begin
          if (stop_btn || !cur_en) begin
            state_q <= ST_IDLE;
          end else if (trig) begin
            state_q    <= ST_RINGING;
            alarm_q    <= 1'b1;
            alarm_id_q <= trig_id;
            ring_cnt_q <= '0;
          end else if (snz_hit) begin
            state_q    <= ST_RINGING;
            alarm_q    <= 1'b1;
            ring_cnt_q <= '0;
          end
        end
`endif
        default: begin
          state_q <= ST_IDLE;
          alarm_q <= 1'b0;
        end
      endcase
    end
  end

  assign alarm     = alarm_q;
  assign alarm_id  = alarm_id_q;
  assign disp_time = disp_q;

endmodule

// File: tb/tb_alarm_clk_core.sv
// Directed bench for alarm_clk_core (10 clk per second, 4 alarms, 3 s ring, 5 min snooze).
module tb_alarm_clk_core;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [2:0]  sel = '0;
  logic [1:0]  edit_btns = '0;
  logic [3:0]  alarm_en = '0;
  logic        snooze_btn = 1'b0;
  logic        stop_btn = 1'b0;
  logic        alarm;
  logic [1:0]  alarm_id;
  logic [16:0] disp_time;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  alarm_clk_core #(
    .CLK_FREQ_HZ (10),
    .N_ALARMS    (4),
    .RING_SECONDS(3),
    .SNOOZE_MIN  (5)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .sel        (sel),
    .edit_btns  (edit_btns),
    .alarm_en   (alarm_en),
    .snooze_btn (snooze_btn),
    .stop_btn   (stop_btn),
    .alarm      (alarm),
    .alarm_id   (alarm_id),
    .disp_time  (disp_time)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [16:0] hms(input int h, input int m, input int s);
    return {5'(h), 6'(m), 6'(s)};
  endfunction

  task automatic do_reset();
    reset = 1'b0; sel = '0; edit_btns = '0; alarm_en = '0;
    snooze_btn = 1'b0; stop_btn = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  // Holds the edit bits for n consecutive edges; returns 1 time unit after the last.
  task automatic press(input logic [2:0] s, input logic [1:0] b, input int n);
    sel = s;
    edit_btns = b;
    repeat (n) @(posedge clk);
    #1 edit_btns = 2'b00;
  endtask

  task automatic adv(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    // Reset values, midnight rollover, minute carry, alarm views
    do_reset();
    chk("rst_disp", disp_time, 0);
    chk("rst_alarm", alarm, 0);
    chk("rst_id", alarm_id, 0);
    press(0, 2'b10, 23);
    press(0, 2'b01, 59);
    adv(581);
    chk("pre_235958", disp_time, hms(23, 59, 58));
    adv(20);
    chk("midnight", disp_time, hms(0, 0, 0));
    adv(600);
    chk("minute_carry", disp_time, hms(0, 1, 0));
    press(1, 2'b10, 25);
    press(1, 2'b01, 61);
    adv(1);
    chk("alarm0_view", disp_time, hms(1, 1, 0));
    press(7, 2'b11, 5);
    adv(1);
    chk("sel_out_of_range", disp_time, hms(0, 1, 9));
    sel = 3'd1;
    adv(1);
    chk("alarm0_kept", disp_time, hms(1, 1, 0));
    sel = 3'd0;

    // Alarm 2 at 07:30 triggers, auto-stops after 3 ticks; edit onto it never triggers
    do_reset();
    press(3, 2'b10, 7);
    press(3, 2'b01, 30);
    alarm_en = 4'b0100;
    press(0, 2'b10, 7);
    press(0, 2'b01, 29);
    adv(599);
    chk("pre_trigger", alarm, 0);
    adv(1);
    chk("trigger", alarm, 1);
    chk("trigger_id", alarm_id, 2);
    adv(1);
    chk("trigger_disp", disp_time, hms(7, 30, 0));
    adv(28);
    chk("ring_hold", alarm, 1);
    adv(1);
    chk("ring_timeout", alarm, 0);
    press(0, 2'b01, 59);
    press(0, 2'b01, 1);
    adv(3);
    chk("edit_no_trigger", alarm, 0);

    // Tie between alarms 1 and 3 at 06:00, hour carry, stop button
    do_reset();
    press(2, 2'b10, 6);
    press(4, 2'b10, 6);
    alarm_en = 4'b1010;
    press(0, 2'b10, 5);
    press(0, 2'b01, 59);
    adv(600);
    chk("tie_alarm", alarm, 1);
    chk("tie_id", alarm_id, 1);
    adv(1);
    chk("hour_carry", disp_time, hms(6, 0, 0));
    stop_btn = 1'b1;
    @(posedge clk);
    #1 stop_btn = 1'b0;
    chk("stop", alarm, 0);

    // Minutes edit coincident with a tick at 10:59:59, both bits at once, hour wrap
    do_reset();
    press(0, 2'b10, 10);
    press(0, 2'b01, 59);
    adv(599);
    press(0, 2'b01, 1);
    adv(1);
    chk("edit_beats_tick", disp_time, hms(10, 0, 0));
    adv(10);
    chk("tick_after_edit", disp_time, hms(10, 0, 1));
    press(0, 2'b11, 1);
    adv(1);
    chk("both_bits", disp_time, hms(11, 1, 0));
    press(0, 2'b10, 13);
    adv(1);
    chk("hour_wrap", disp_time, hms(0, 1, 0));

    // Ring at 23:58 then snooze
    do_reset();
    press(1, 2'b10, 23);
    press(1, 2'b01, 58);
    alarm_en = 4'b0001;
    press(0, 2'b10, 23);
    press(0, 2'b01, 57);
    adv(600);
    chk("snz_trigger", alarm, 1);
    chk("snz_trigger_id", alarm_id, 0);
    adv(4);
    snooze_btn = 1'b1;
    @(posedge clk);
    #1 snooze_btn = 1'b0;
`ifdef ALARM_CLK_SNOOZE_EN
    chk("snoozed", alarm, 0);
    adv(2994);
    chk("snooze_wait", alarm, 0);
    adv(1);
    chk("snooze_ring", alarm, 1);
    chk("snooze_ring_id", alarm_id, 0);
    adv(1);
    chk("snooze_disp", disp_time, hms(0, 3, 0));
    adv(1);
    stop_btn = 1'b1;
    snooze_btn = 1'b1;
    @(posedge clk);
    #1;
    stop_btn = 1'b0;
    snooze_btn = 1'b0;
    chk("stop_wins", alarm, 0);
    adv(3000);
    chk("no_resnooze", alarm, 0);
`else
    chk("snooze_ignored", alarm, 1);
    adv(24);
    chk("snooze_ignored_hold", alarm, 1);
    adv(1);
    chk("snooze_ignored_timeout", alarm, 0);
`endif

    // Enable deassert while ringing
    do_reset();
    press(1, 2'b01, 1);
    alarm_en = 4'b0001;
    press(0, 2'b01, 60);
    adv(600);
    chk("en_trigger", alarm, 1);
    alarm_en = 4'b0000;
    adv(1);
    chk("en_drop", alarm, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
